uart_tx_fifo: RTL and testbench

Buffered, runtime-configurable UART transmitter and successor to the fixed-format single-word transmitter. Words are pushed through a valid/ready handshake into an internal FIFO and serialised LSB-first. The baud divisor, parity mode and stop-bit count are set per frame. It sits between the CPU's memory-mapped UART register block and the board TX pin, so software can queue bursts without polling per byte.

---
 rtl/uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// sync_fifo: circular-buffer FIFO with an occupancy counter; pointers wrap at DEPTH.
// Latency: a pushed word reaches the head one cycle after its push edge.
// Backpressure: full_o rises at DEPTH entries, and the caller must not push while it is high.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage write. The contents are not reset, because count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers and occupancy. A push and a pop in the same cycle cancel in the count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == FULL_CNT);
endmodule

// uart_tx_fifo: buffered UART transmitter with a per-frame divisor, parity mode and stop-bit count.
// Latency: a word pushed into an empty, idle block starts its start bit one edge after the push.
// Backpressure: ready drops while the FIFO is full; the word in the shifter does not count as queued.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  output logic                  sig,
  output logic                  busy,
  output logic                  tx_done,
  output logic [CW-1:0]         fifo_count
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sig_q, sig_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop2_q, stop2_d;
  logic                   stop_second_q, stop_second_d;

  logic                   push_w;
  logic                   pop_w;
  logic                   full_w;
  logic [DATA_WIDTH-1:0]  head_dat_w;
  logic [CW-1:0]          count_w;
  logic [DIV_WIDTH-1:0]   div_clamp_w;

  assign ready  = ~full_w;
  assign push_w = valid & ready;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (push_w),
    .push_dat_i (data),
    .pop_i      (pop_w),
    .head_dat_o (head_dat_w),
    .count_o    (count_w),
    .full_o     (full_w)
  );

  assign fifo_count = count_w;

  // Divisors below 2 would collapse the bit timing, so they are raised to 2.
  assign div_clamp_w = (divisor < MIN_DIV) ? MIN_DIV : divisor;

  // Next-state and frame datapath. The configuration is captured only at the pop that starts a frame.
  always_comb begin
    state_d       = state_q;
    sig_d         = sig_q;
    tx_done_d     = 1'b0;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    div_d         = div_q;
    par_en_d      = par_en_q;
    par_bit_d     = par_bit_q;
    stop2_d       = stop2_q;
    stop_second_d = stop_second_q;
    pop_w         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sig_d = 1'b1;
        if (count_w != '0) begin
          pop_w         = 1'b1;
          shift_d       = head_dat_w;
          div_d         = div_clamp_w;
          cnt_d         = div_clamp_w - ONE;
          bit_d         = '0;
          par_en_d      = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d     = (parity_mode == 2'b10) ? ~^head_dat_w : ^head_dat_w;
          stop2_d       = stop2;
          stop_second_d = 1'b0;
          sig_d         = 1'b0;
          state_d       = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q - ONE;
          sig_d   = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - ONE;
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              sig_d   = par_bit_q;
              state_d = ST_PARITY;
            end else begin
              sig_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            sig_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ST_PARITY: begin
        if (cnt_q == '0) begin
          cnt_d         = div_q - ONE;
          sig_d         = 1'b1;
          stop_second_d = 1'b0;
          state_d       = ST_STOP;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ST_STOP: begin
        if (cnt_q == '0) begin
          if (stop2_q && !stop_second_q) begin
            // The second stop bit re-arms the counter, so it never has to hold 2D.
            stop_second_d = 1'b1;
            cnt_d         = div_q - ONE;
          end else begin
            tx_done_d = 1'b1;
            sig_d     = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      default: begin
        sig_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output flops. Reset drops any in-flight word without a tx_done pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      sig_q         <= 1'b1;
      busy_q        <= 1'b0;
      tx_done_q     <= 1'b0;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      div_q         <= MIN_DIV;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sig_q         <= sig_d;
      busy_q        <= busy_d;
      tx_done_q     <= tx_done_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      div_q         <= div_d;
      par_en_q      <= par_en_d;
      par_bit_q     <= par_bit_d;
      stop2_q       <= stop2_d;
      stop_second_q <= stop_second_d;
    end
  end

  assign sig     = sig_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with hand-computed frame images.
// Latency: samples are taken 1 time unit after each rising edge, or on the falling edge for the line monitor.
// Backpressure: the throughput case holds valid high until ready drops.
module tb_uart_tx_fifo;
  logic        clk;
  logic        rstn;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [15:0] divisor;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        sig;
  logic        busy;
  logic        tx_done;
  logic [4:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic mon_en = 1'b0;
  logic mon_q[$];

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .DIV_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .divisor     (divisor),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .sig         (sig),
    .busy        (busy),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line monitor for the burst case.
  always @(negedge clk) begin
    if (mon_en) mon_q.push_back(sig);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Samples a frame that starts at the current sample point (cycle 0, right after the pop edge).
  // bits[i] is the level of bit-time i. glitches counts samples that differ within a bit-time.
  // The sample after the last bit-time is also inspected for the tx_done pulse.
  task automatic capture(input int d, input int nbits, output logic [31:0] bits,
                         output int glitches, output int done_k, output int done_n);
    int total;
    total    = d * nbits;
    bits     = '0;
    glitches = 0;
    done_k   = -1;
    done_n   = 0;
    for (int k = 0; k <= total; k++) begin
      if (k < total) begin
        if (k % d == 0) bits[k / d] = sig;
        else if (sig !== bits[k / d]) glitches++;
      end
      if (tx_done === 1'b1) begin
        done_n++;
        done_k = k;
      end
      if (k < total) tick;
    end
  endtask

  logic [31:0] bits;
  int glitches, done_k, done_n;
  int cnt_a, cnt_b, cnt_c, cnt_d;
  int accepted, drained, s, nxt, nfr, max_gap;
  logic [3:0] early;
  logic [7:0] b;
  logic       frm_ok;

  initial begin
    rstn = 1'b0; valid = 1'b0; data = '0;
    divisor = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;

    // Reset values.
    tick;
    check("rst_sig", sig, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_count", fifo_count, 0);
    tick;
    rstn = 1'b1;

    // Idle for 100 cycles.
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (sig !== 1'b1) cnt_a++;
      if (tx_done !== 1'b0) cnt_b++;
      if (busy !== 1'b0 || ready !== 1'b1) cnt_c++;
      if (fifo_count !== 5'd0) cnt_d++;
    end
    check("idle_sig_low", cnt_a, 0);
    check("idle_tx_done", cnt_b, 0);
    check("idle_busy_ready", cnt_c, 0);
    check("idle_count", cnt_d, 0);

    // 0xA5, divisor 4, even parity, one stop bit.
    divisor = 16'd4; parity_mode = 2'b01; stop2 = 1'b0;
    data = 8'hA5; valid = 1'b1;
    tick;
    valid = 1'b0;
    check("a5_count_after_push", fifo_count, 1);
    check("a5_busy_after_push", busy, 0);
    tick;
    check("a5_pop_sig", sig, 0);
    check("a5_pop_busy", busy, 1);
    check("a5_pop_count", fifo_count, 0);
    capture(4, 11, bits, glitches, done_k, done_n);
    check("a5_bits", bits, {1'b1, 1'b0, 8'hA5, 1'b0});
    check("a5_glitch", glitches, 0);
    check("a5_done_at", done_k, 44);
    check("a5_done_pulses", done_n, 1);
    tick;
    check("a5_after_busy", busy, 0);
    check("a5_after_done", tx_done, 0);
    check("a5_after_sig", sig, 1);

    // 0x01, divisor 4, odd parity, two stop bits.
    divisor = 16'd4; parity_mode = 2'b10; stop2 = 1'b1;
    data = 8'h01; valid = 1'b1;
    tick;
    valid = 1'b0;
    tick;
    capture(4, 12, bits, glitches, done_k, done_n);
    check("odd_bits", bits, {1'b1, 1'b1, 1'b0, 8'h01, 1'b0});
    check("odd_glitch", glitches, 0);
    check("odd_done_at", done_k, 48);
    tick;

    // The configuration changes while frame 1 is on the line and applies only to frame 2.
    divisor = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    data = 8'h3C; valid = 1'b1;
    tick;
    data = 8'h07;
    tick;
    valid = 1'b0;
    divisor = 16'd8; parity_mode = 2'b01;
    check("cfg_count", fifo_count, 1);
    capture(4, 10, bits, glitches, done_k, done_n);
    check("cfg_f1_bits", bits, {1'b1, 8'h3C, 1'b0});
    check("cfg_f1_glitch", glitches, 0);
    check("cfg_f1_done_at", done_k, 40);
    tick;
    capture(8, 11, bits, glitches, done_k, done_n);
    check("cfg_f2_bits", bits, {1'b1, 1'b1, 8'h07, 1'b0});
    check("cfg_f2_glitch", glitches, 0);
    check("cfg_f2_done_at", done_k, 88);
    tick;
    check("cfg_end_busy", busy, 0);
    check("cfg_end_count", fifo_count, 0);

    // Burst with valid held high: 17 words are accepted, then ready falls.
    divisor = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
    mon_q.delete();
    mon_en = 1'b1;
    data = 8'h00; valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 60; i++) begin
      if (ready !== 1'b1) break;
      tick;
      accepted++;
      data = data + 8'd1;
    end
    valid = 1'b0;
    check("tp_accepted", accepted, 17);
    check("tp_ready_low", ready, 0);
    check("tp_count_full", fifo_count, 16);
    drained = 0;
    for (int i = 0; i < 800; i++) begin
      tick;
      if (busy === 1'b0 && fifo_count === 5'd0) begin
        drained = 1;
        break;
      end
    end
    check("tp_drained", drained, 1);
    for (int i = 0; i < 30; i++) tick;
    mon_en = 1'b0;

    // Decode the captured line: 20 cycles per frame at divisor 2, data samples taken late in each bit.
    s = -1;
    for (int i = 0; i < mon_q.size(); i++) begin
      if (mon_q[i] === 1'b0) begin
        s = i;
        break;
      end
    end
    nfr = 0;
    max_gap = 0;
    nxt = -1;
    for (int f = 0; f < 17; f++) begin
      if (s < 0 || s + 20 > mon_q.size()) break;
      b = '0;
      for (int i = 0; i < 8; i++) b[i] = mon_q[s + 2 * i + 3];
      frm_ok = (mon_q[s + 1] === 1'b0) && (mon_q[s + 18] === 1'b1) && (mon_q[s + 19] === 1'b1);
      check($sformatf("tp_frame%0d", f), {frm_ok, b}, {1'b1, 8'(f)});
      nfr++;
      nxt = -1;
      for (int j = s + 20; j < mon_q.size(); j++) begin
        if (mon_q[j] === 1'b0) begin
          nxt = j;
          break;
        end
      end
      if (f < 16 && nxt >= 0 && nxt - (s + 20) > max_gap) max_gap = nxt - (s + 20);
      s = nxt;
    end
    check("tp_frames", nfr, 17);
    // Queued frames follow with less than one bit-time of idle line between them.
    check("tp_contiguous", (max_gap < 2), 1);
    check("tp_no_extra_frame", nxt, -1);

    // divisor 0 acts as 2; reset mid-DATA with three words queued.
    divisor = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
    valid = 1'b1;
    data = 8'h55; tick;
    data = 8'hAA; tick;
    data = 8'h0F; tick;
    data = 8'hF0; tick;
    valid = 1'b0;
    early[0] = sig; tick;
    early[1] = sig; tick;
    early[2] = sig; tick;
    early[3] = sig;
    check("div0_bits", early, 4'b0011);
    check("div0_queued", fifo_count, 3);
    check("div0_busy", busy, 1);
    rstn = 1'b0;
    tick;
    check("midrst_sig", sig, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 1);
    rstn = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (sig !== 1'b1) cnt_a++;
      if (tx_done !== 1'b0) cnt_b++;
      if (busy !== 1'b0) cnt_c++;
    end
    check("post_rst_sig", cnt_a, 0);
    check("post_rst_tx_done", cnt_b, 0);
    check("post_rst_busy", cnt_c, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
